mem_port_arbiter: RTL and testbench

- Shares the single Data_Memory instance between the instruction-fetch port (read-only) and the MEM-stage load/store port of the RV32IM pipeline.
- Grants one requester at a time and latches its request.
- Sequences the memory's Read/Write/busywait handshake and returns data and busywait to the granted stage.
- Has a watchdog that aborts hung accesses.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_watchdog.sv | 39 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state encoding and func3 size codes for the data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2
    } arb_state_e;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_SB  = 3'b000;
    localparam logic [2:0] FUNC3_SH  = 3'b001;
    localparam logic [2:0] FUNC3_SW  = 3'b010;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts SERVE cycles, flags expiry, and latches a sticky
// timeout error until reset.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic count_en,
    output logic expired,
    output logic Timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tcnt;
    logic             r_timeout_err;

    // Count saturates at the limit so an expired count never wraps.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (clear) begin
                r_tcnt <= '0;
            end else if (count_en && !expired) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (count_en && expired) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign expired     = (r_tcnt == CNT_W'(TIMEOUT_CYCLES));
    assign Timeout_err = r_timeout_err;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Data_Memory between the fetch port and the MEM-stage port.
// ARB_ROUND_ROBIN_EN: alternate grants when both ports request (default: D over I).
//   state   | meaning
//   IDLE    | no access in flight, arbitrate this cycle
//   SERVE_D | load/store access in flight for the MEM stage
//   SERVE_I | instruction fetch in flight
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              I_Read,
    input  logic [ADDR_W-1:0] I_Address,
    output logic [DATA_W-1:0] I_Read_data,
    output logic              I_busywait,
    input  logic              D_Read,
    input  logic              D_Write,
    input  logic [ADDR_W-1:0] D_Address,
    input  logic [DATA_W-1:0] D_Write_data,
    input  logic [2:0]        D_Func3,
    output logic [DATA_W-1:0] D_Read_data,
    output logic              D_busywait,
    output logic              Mem_Read,
    output logic              Mem_Write,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Write_data,
    output logic [2:0]        Mem_Func3,
    input  logic [DATA_W-1:0] Mem_Read_data,
    input  logic              Mem_busywait,
    output logic              Timeout_err
);

    arb_state_e        r_state, w_next_state;
    logic [ADDR_W-1:0] r_lat_addr;
    logic [DATA_W-1:0] r_lat_wdata;
    logic [2:0]        r_lat_func3;
    logic              r_lat_wr, r_started, r_mem_rd, r_mem_wr;
    logic [DATA_W-1:0] r_i_hold, r_d_hold;
    logic              w_d_req, w_grant_d, w_grant_i, w_done, w_expired;
    logic              w_done_d, w_done_i;
    logic [DATA_W-1:0] w_rdata;

    assign w_d_req = D_Read | D_Write;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;  // 0 = D granted last, 1 = I granted last

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_last_grant <= 1'b0;
        end else if (w_grant_d || w_grant_i) begin
            r_last_grant <= w_grant_i;
        end
    end

    assign w_grant_d = (r_state == IDLE) && w_d_req && (!I_Read || r_last_grant);
`else
    assign w_grant_d = (r_state == IDLE) && w_d_req;
`endif
    assign w_grant_i = (r_state == IDLE) && I_Read && !w_grant_d;

    assign w_done   = (r_state != IDLE) && ((r_started && !Mem_busywait) || w_expired);
    assign w_done_d = (r_state == SERVE_D) && w_done;
    assign w_done_i = (r_state == SERVE_I) && w_done;
    assign w_rdata  = w_expired ? '0 : Mem_Read_data;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d)      w_next_state = SERVE_D;
                else if (w_grant_i) w_next_state = SERVE_I;
            end
            SERVE_D, SERVE_I: begin
                if (w_done) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request fields are captured once at grant; later requester changes are ignored.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_lat_addr  <= '0;
            r_lat_wdata <= '0;
            r_lat_func3 <= '0;
            r_lat_wr    <= 1'b0;
            r_started   <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_i_hold    <= '0;
            r_d_hold    <= '0;
        end else if (w_grant_d) begin
            r_lat_addr  <= D_Address;
            r_lat_wdata <= D_Write_data;
            r_lat_func3 <= D_Func3;
            r_lat_wr    <= D_Write;
            r_started   <= 1'b0;
            r_mem_rd    <= !D_Write;
            r_mem_wr    <= D_Write;
        end else if (w_grant_i) begin
            r_lat_addr  <= I_Address;
            r_lat_func3 <= FUNC3_LW;
            r_lat_wr    <= 1'b0;
            r_started   <= 1'b0;
            r_mem_rd    <= 1'b1;
            r_mem_wr    <= 1'b0;
        end else if (w_done) begin
            r_started <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            if (w_done_d && !r_lat_wr) r_d_hold <= w_rdata;
            if (w_done_i)              r_i_hold <= w_rdata;
        end else if (r_state != IDLE) begin
            r_started <= 1'b1;
        end
    end

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .Clock       (Clock),
        .Reset       (Reset),
        .clear       (w_grant_d | w_grant_i),
        .count_en    (r_state != IDLE),
        .expired     (w_expired),
        .Timeout_err (Timeout_err)
    );

    assign I_busywait     = I_Read && !w_done_i;
    assign D_busywait     = w_d_req && !w_done_d;
    assign I_Read_data    = w_done_i ? w_rdata : r_i_hold;
    assign D_Read_data    = (w_done_d && !r_lat_wr) ? w_rdata : r_d_hold;
    assign Mem_Read       = r_mem_rd;
    assign Mem_Write      = r_mem_wr;
    assign Mem_Address    = r_lat_addr;
    assign Mem_Write_data = r_lat_wdata;
    assign Mem_Func3      = r_lat_func3;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbiter and a small word memory.
module tb_mem_port_arbiter;

    localparam int TO = 255;

    logic        Clock, Reset;
    logic        I_Read, I_busywait, D_Read, D_Write, D_busywait;
    logic [31:0] I_Address, I_Read_data, D_Address, D_Write_data, D_Read_data;
    logic [2:0]  D_Func3, Mem_Func3;
    logic        Mem_Read, Mem_Write, Mem_busywait, Timeout_err;
    logic [31:0] Mem_Address, Mem_Write_data, Mem_Read_data;

    int          checks = 0;
    int          errors = 0;
    int          busy_mode = 0;   // 0: never stall, 1: always stall, 2: random stall
    logic [31:0] mem [16];

    mem_port_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .I_Read(I_Read), .I_Address(I_Address), .I_Read_data(I_Read_data), .I_busywait(I_busywait),
        .D_Read(D_Read), .D_Write(D_Write), .D_Address(D_Address), .D_Write_data(D_Write_data),
        .D_Func3(D_Func3), .D_Read_data(D_Read_data), .D_busywait(D_busywait),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Address(Mem_Address),
        .Mem_Write_data(Mem_Write_data), .Mem_Func3(Mem_Func3),
        .Mem_Read_data(Mem_Read_data), .Mem_busywait(Mem_busywait), .Timeout_err(Timeout_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Word memory standing in for Data_Memory; a write lands when not stalled.
    always @(negedge Clock) begin
        if (Mem_Write === 1'b1 && Mem_busywait === 1'b0) mem[Mem_Address[5:2]] = Mem_Write_data;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
        case (busy_mode)
            0:       Mem_busywait = 1'b0;
            1:       Mem_busywait = 1'b1;
            default: Mem_busywait = 1'($urandom_range(0, 1));
        endcase
        Mem_Read_data = mem[Mem_Address[5:2]];
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        @(negedge Clock);
        checks++; if (Mem_Read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got %b exp 0", Mem_Read); end
        checks++; if (Mem_Write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %b exp 0", Mem_Write); end
        checks++; if (D_Read_data !== 32'h0) begin errors++; $display("FAIL rst_d_rdata got %h exp 0", D_Read_data); end
        checks++; if (I_Read_data !== 32'h0) begin errors++; $display("FAIL rst_i_rdata got %h exp 0", I_Read_data); end
        checks++; if (Timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", Timeout_err); end
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_write();
        tick();
        D_Write = 1'b1; D_Address = 32'h4; D_Write_data = 32'h12345678; D_Func3 = 3'b010;
        @(negedge Clock);
        checks++; if (D_busywait !== 1'b1) begin errors++; $display("FAIL wr_bw_c0 got %b exp 1", D_busywait); end
        checks++; if (Mem_Write !== 1'b0) begin errors++; $display("FAIL wr_mem_write_c0 got %b exp 0", Mem_Write); end
        tick();
        @(negedge Clock);
        checks++; if (Mem_Write !== 1'b1) begin errors++; $display("FAIL wr_mem_write got %b exp 1", Mem_Write); end
        checks++; if (Mem_Read !== 1'b0) begin errors++; $display("FAIL wr_mem_read got %b exp 0", Mem_Read); end
        checks++; if (Mem_Address !== 32'h4) begin errors++; $display("FAIL wr_addr got %h exp 4", Mem_Address); end
        checks++; if (Mem_Write_data !== 32'h12345678) begin errors++; $display("FAIL wr_wdata got %h exp 12345678", Mem_Write_data); end
        checks++; if (Mem_Func3 !== 3'b010) begin errors++; $display("FAIL wr_func3 got %b exp 010", Mem_Func3); end
        checks++; if (D_busywait !== 1'b1) begin errors++; $display("FAIL wr_bw_c1 got %b exp 1", D_busywait); end
        tick();
        @(negedge Clock);
        checks++; if (D_busywait !== 1'b0) begin errors++; $display("FAIL wr_bw_done got %b exp 0", D_busywait); end
        checks++; if (I_busywait !== 1'b0) begin errors++; $display("FAIL wr_i_bw got %b exp 0", I_busywait); end
        tick();
        D_Write = 1'b0;
        @(negedge Clock);
        checks++; if (Mem_Write !== 1'b0) begin errors++; $display("FAIL wr_mem_write_idle got %b exp 0", Mem_Write); end
        checks++; if (Mem_Address !== 32'h4) begin errors++; $display("FAIL wr_addr_hold got %h exp 4", Mem_Address); end
    endtask

    task automatic test_read(input logic [31:0] addr, input logic [31:0] exp_data, input int exp_bw);
        int bw = 0;
        bit done = 0;
        tick();
        D_Read = 1'b1; D_Address = addr; D_Func3 = 3'b010;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge Clock);
            if (D_busywait === 1'b1) bw++;
            else begin
                done = 1;
                checks++; if (D_Read_data !== exp_data) begin errors++; $display("FAIL rd_data got %h exp %h", D_Read_data, exp_data); end
            end
            if (!done) tick();
        end
        checks++; if (!done) begin errors++; $display("FAIL rd_complete got 0 exp 1"); end
        checks++; if (bw != exp_bw) begin errors++; $display("FAIL rd_bw_cycles got %0d exp %0d", bw, exp_bw); end
        tick();
        D_Read = 1'b0;
        @(negedge Clock);
        checks++; if (D_Read_data !== exp_data) begin errors++; $display("FAIL rd_hold got %h exp %h", D_Read_data, exp_data); end
        checks++; if (D_busywait !== 1'b0) begin errors++; $display("FAIL rd_bw_idle got %b exp 0", D_busywait); end
    endtask

`ifndef ARB_ROUND_ROBIN_EN
    task automatic test_collision();
        tick();
        I_Read = 1'b1; I_Address = 32'h10;
        D_Read = 1'b1; D_Address = 32'h5; D_Func3 = 3'b000;
        @(negedge Clock);
        checks++; if (I_busywait !== 1'b1 || D_busywait !== 1'b1) begin errors++; $display("FAIL col_bw_c0 got %b%b exp 11", I_busywait, D_busywait); end
        busy_mode = 1;
        tick();
        @(negedge Clock);
        checks++; if (Mem_Read !== 1'b1) begin errors++; $display("FAIL col_d_read got %b exp 1", Mem_Read); end
        checks++; if (Mem_Address !== 32'h5) begin errors++; $display("FAIL col_d_addr got %h exp 5", Mem_Address); end
        checks++; if (Mem_Func3 !== 3'b000) begin errors++; $display("FAIL col_d_func3 got %b exp 000", Mem_Func3); end
        tick();
        D_Address = 32'h20;
        @(negedge Clock);
        checks++; if (Mem_Address !== 32'h5) begin errors++; $display("FAIL col_addr_ignored got %h exp 5", Mem_Address); end
        checks++; if (I_busywait !== 1'b1) begin errors++; $display("FAIL col_i_bw_stall got %b exp 1", I_busywait); end
        busy_mode = 0;
        tick();
        @(negedge Clock);
        checks++; if (D_busywait !== 1'b0) begin errors++; $display("FAIL col_d_done got %b exp 0", D_busywait); end
        checks++; if (D_Read_data !== 32'h12345678) begin errors++; $display("FAIL col_d_data got %h exp 12345678", D_Read_data); end
        checks++; if (I_busywait !== 1'b1) begin errors++; $display("FAIL col_i_bw_d_done got %b exp 1", I_busywait); end
        tick();
        D_Read = 1'b0;
        @(negedge Clock);
        checks++; if (Mem_Read !== 1'b0) begin errors++; $display("FAIL col_idle_read got %b exp 0", Mem_Read); end
        tick();
        @(negedge Clock);
        checks++; if (Mem_Read !== 1'b1 || Mem_Address !== 32'h10) begin errors++; $display("FAIL col_i_access got rd=%b addr=%h exp rd=1 addr=10", Mem_Read, Mem_Address); end
        checks++; if (Mem_Func3 !== 3'b010) begin errors++; $display("FAIL col_i_func3 got %b exp 010", Mem_Func3); end
        tick();
        @(negedge Clock);
        checks++; if (I_busywait !== 1'b0) begin errors++; $display("FAIL col_i_done got %b exp 0", I_busywait); end
        checks++; if (I_Read_data !== 32'hCAFEF00D) begin errors++; $display("FAIL col_i_data got %h exp cafef00d", I_Read_data); end
        tick();
        I_Read = 1'b0;
        @(negedge Clock);
        checks++; if (I_Read_data !== 32'hCAFEF00D) begin errors++; $display("FAIL col_i_hold got %h exp cafef00d", I_Read_data); end
    endtask
`endif

    task automatic test_timeout();
        int  bw = 0;
        bit  done = 0;
        busy_mode = 1;
        tick();
        D_Read = 1'b1; D_Address = 32'h8; D_Func3 = 3'b010;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge Clock);
            if (D_busywait === 1'b1) bw++;
            else begin
                done = 1;
                checks++; if (D_Read_data !== 32'h0) begin errors++; $display("FAIL to_data got %h exp 0", D_Read_data); end
                checks++; if (Timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_early got %b exp 0", Timeout_err); end
            end
            if (!done) tick();
        end
        checks++; if (!done) begin errors++; $display("FAIL to_abort got 0 exp 1"); end
        checks++; if (bw != TO + 1) begin errors++; $display("FAIL to_bw_cycles got %0d exp %0d", bw, TO + 1); end
        busy_mode = 0;
        tick();
        D_Read = 1'b0;
        @(negedge Clock);
        checks++; if (Timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", Timeout_err); end
        checks++; if (D_Read_data !== 32'h0) begin errors++; $display("FAIL to_hold got %h exp 0", D_Read_data); end
        test_read(32'h4, 32'h12345678, 2);
        checks++; if (Timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %b exp 1", Timeout_err); end
    endtask

    task automatic test_reset_mid();
        busy_mode = 1;
        tick();
        I_Read = 1'b1; I_Address = 32'h10;
        @(negedge Clock);
        tick();
        @(negedge Clock);
        checks++; if (Mem_Read !== 1'b1) begin errors++; $display("FAIL rm_serving got %b exp 1", Mem_Read); end
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        @(negedge Clock);
        checks++; if (Mem_Read !== 1'b0) begin errors++; $display("FAIL rm_mem_read got %b exp 0", Mem_Read); end
        checks++; if (I_Read_data !== 32'h0) begin errors++; $display("FAIL rm_i_data got %h exp 0", I_Read_data); end
        checks++; if (D_Read_data !== 32'h0) begin errors++; $display("FAIL rm_d_data got %h exp 0", D_Read_data); end
        checks++; if (Timeout_err !== 1'b0) begin errors++; $display("FAIL rm_timeout got %b exp 0", Timeout_err); end
        checks++; if (I_busywait !== 1'b1) begin errors++; $display("FAIL rm_i_bw got %b exp 1", I_busywait); end
        busy_mode = 0;
        tick();
        @(negedge Clock);
        checks++; if (Mem_Read !== 1'b1) begin errors++; $display("FAIL rm_regrant got %b exp 1", Mem_Read); end
        tick();
        @(negedge Clock);
        checks++; if (I_Read_data !== 32'hCAFEF00D) begin errors++; $display("FAIL rm_i_refetch got %h exp cafef00d", I_Read_data); end
        tick();
        I_Read = 1'b0;
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        int   grants = 0;
        logic prev_rd = 1'b0;
        logic exp_i = 1'b1;   // after reset D counts as granted last
        busy_mode = 0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        D_Read = 1'b1; D_Address = 32'h4; D_Func3 = 3'b010;
        I_Read = 1'b1; I_Address = 32'h10;
        for (int k = 0; k < 40 && grants < 4; k++) begin
            @(negedge Clock);
            if (Mem_Read === 1'b1 && prev_rd === 1'b0) begin
                checks++; if ((Mem_Address == 32'h10) !== exp_i) begin errors++; $display("FAIL rr_grant%0d got addr %h exp i=%b", grants, Mem_Address, exp_i); end
                exp_i = ~exp_i;
                grants++;
            end
            prev_rd = Mem_Read;
            tick();
        end
        checks++; if (grants != 4) begin errors++; $display("FAIL rr_grant_count got %0d exp 4", grants); end
        D_Read = 1'b0; I_Read = 1'b0;
    endtask
`endif

    task automatic test_random();
        int          srv = 0;      // 0 none, 1 D, 2 I
        int          age = 0;
        logic [31:0] e_addr = '0, e_wd = '0, m_dhold = '0, m_ihold = '0, ed_rd, ei_rd, val;
        logic [2:0]  e_f3 = '0;
        logic        e_wr = 1'b0, m_last = 1'b0, gd, dreq, ireq, ed_bw, ei_bw, fin;
        logic        d_fin = 1'b0, i_fin = 1'b0;
        int          kind;
        D_Read = 1'b0; D_Write = 1'b0; I_Read = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        busy_mode = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (d_fin && $urandom_range(0, 3) != 0) begin D_Read = 1'b0; D_Write = 1'b0; end
            if (i_fin && $urandom_range(0, 3) != 0) I_Read = 1'b0;
            if (!(D_Read || D_Write) && $urandom_range(0, 2) == 0) begin
                kind = $urandom_range(0, 2);
                D_Read = (kind != 1); D_Write = (kind != 0);
                D_Address = 32'($urandom_range(0, 15)) << 2;
                D_Write_data = $urandom();
                D_Func3 = 3'($urandom_range(0, 7));
            end
            if (!I_Read && $urandom_range(0, 2) == 0) begin
                I_Read = 1'b1;
                I_Address = 32'($urandom_range(0, 15)) << 2;
            end
            @(negedge Clock);
            dreq = D_Read | D_Write; ireq = I_Read;
            ed_bw = dreq; ei_bw = ireq; ed_rd = m_dhold; ei_rd = m_ihold;
            if (srv == 0) begin
                checks++; if (Mem_Read !== 1'b0 || Mem_Write !== 1'b0) begin errors++; $display("FAIL rnd_idle_strobe got rd=%b wr=%b exp 0 0", Mem_Read, Mem_Write); end
`ifdef ARB_ROUND_ROBIN_EN
                gd = (dreq && ireq) ? m_last : dreq;
`else
                gd = dreq;
`endif
                if (gd) begin
                    srv = 1; e_addr = D_Address; e_wr = D_Write; e_f3 = D_Func3; e_wd = D_Write_data; m_last = 1'b0;
                end else if (ireq) begin
                    srv = 2; e_addr = I_Address; e_wr = 1'b0; e_f3 = 3'b010; m_last = 1'b1;
                end
                age = 0;
            end else begin
                checks++; if (Mem_Read !== !e_wr || Mem_Write !== e_wr) begin errors++; $display("FAIL rnd_strobe got rd=%b wr=%b exp wr=%b", Mem_Read, Mem_Write, e_wr); end
                checks++; if (Mem_Address !== e_addr || Mem_Func3 !== e_f3) begin errors++; $display("FAIL rnd_fields got %h/%b exp %h/%b", Mem_Address, Mem_Func3, e_addr, e_f3); end
                if (e_wr) begin
                    checks++; if (Mem_Write_data !== e_wd) begin errors++; $display("FAIL rnd_wdata got %h exp %h", Mem_Write_data, e_wd); end
                end
                fin = (age >= 1 && !Mem_busywait) || (age == TO);
                if (fin) begin
                    if (!e_wr) begin
                        val = (age == TO) ? 32'h0 : mem[e_addr[5:2]];
                        if (srv == 1) begin m_dhold = val; ed_rd = val; end
                        else begin m_ihold = val; ei_rd = val; end
                    end
                    if (srv == 1) ed_bw = 1'b0; else ei_bw = 1'b0;
                    srv = 0;
                end else begin
                    age++;
                end
            end
            checks++; if (D_busywait !== ed_bw) begin errors++; $display("FAIL rnd_d_bw cyc %0d got %b exp %b", cyc, D_busywait, ed_bw); end
            checks++; if (I_busywait !== ei_bw) begin errors++; $display("FAIL rnd_i_bw cyc %0d got %b exp %b", cyc, I_busywait, ei_bw); end
            checks++; if (D_Read_data !== ed_rd) begin errors++; $display("FAIL rnd_d_data cyc %0d got %h exp %h", cyc, D_Read_data, ed_rd); end
            checks++; if (I_Read_data !== ei_rd) begin errors++; $display("FAIL rnd_i_data cyc %0d got %h exp %h", cyc, I_Read_data, ei_rd); end
            d_fin = dreq && !ed_bw;
            i_fin = ireq && !ei_bw;
        end
        D_Read = 1'b0; D_Write = 1'b0; I_Read = 1'b0;
        busy_mode = 0;
    endtask

    initial begin
        Reset = 1'b1;
        I_Read = 1'b0; I_Address = '0;
        D_Read = 1'b0; D_Write = 1'b0; D_Address = '0; D_Write_data = '0; D_Func3 = '0;
        Mem_busywait = 1'b0; Mem_Read_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[2] = 32'hA5A5A5A5;
        mem[4] = 32'hCAFEF00D;

        test_reset();
        test_write();
        test_read(32'h4, 32'h12345678, 2);
`ifndef ARB_ROUND_ROBIN_EN
        test_collision();
`endif
        test_timeout();
        test_reset_mid();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
